inst_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface. Owns the PC and drives chip-enable and address to the instruction ROM.
- Captures each returned word, tagged with its PC, into a small prefetch FIFO.
- Presents FIFO head words to the decode stage under a valid/ready handshake.
- Handles redirects (branch/jump) by flushing in-flight words and reloading the PC.

---
 rtl/inst_fetch_unit_pkg.sv | 26 ++
 rtl/inst_fetch_unit_fetch_fifo.sv | 92 +++++++++
 rtl/inst_fetch_unit.sv | 102 ++++++++++
 tb/tb_inst_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Provides bus widths, control levels, the PC step and the prefetch entry layout.
package inst_fetch_unit_pkg;

  localparam int unsigned inst_addr_bus_width = 32;

  typedef logic [inst_addr_bus_width-1:0] InstBus;

  localparam InstBus zero_word      = 32'h0000_0000;
  localparam logic   enable_signal  = 1'b1;
  localparam logic   disable_signal = 1'b0;
  localparam InstBus PC_STEP        = 32'h0000_0004;

  typedef struct packed {
    InstBus pc;
    InstBus inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Redirect targets are forced onto a word boundary.
  function automatic InstBus word_align(input InstBus addr);
    return {addr[inst_addr_bus_width-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} entries.
// Flush has priority over push and pop; head reads as zero while empty.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full    = (count_q == CNT_FULL);
    empty   = (count_q == {CNT_W{1'b0}});
    count   = count_q;
    push_ok = push & ~full & ~flush;
    pop_ok  = pop & ~empty & ~flush;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= {PTR_W{1'b0}};
      wr_ptr  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr  <= {PTR_W{1'b0}};
      wr_ptr  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; stale slots are never visible because head is gated by empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= din;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Head presentation.
  always_comb begin
    if (empty) begin
      head = {WIDTH{1'b0}};
    end else begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction ROM and feeds
// decode from a prefetch FIFO, with redirect flushing on branch/jump.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter InstBus      RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BUF_DEPTH);

  InstBus                pc;
  logic                  running;
  logic                  ce;
  logic                  fetch;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;
  logic                  fifo_full_unused;

  assign fifo_full_unused = fifo_full;

  // Fetch/pop control; ce never depends on id_ready_i, and a redirect cancels both.
  always_comb begin
    ce              = running & (fifo_count < CNT_LIMIT);
    fetch           = ce & ~branch_flag_i;
    pop             = ~fifo_empty & id_ready_i & ~branch_flag_i;
    push_entry.pc   = pc;
    push_entry.inst = rom_inst_i;
    head_entry      = fetch_entry_t'(fifo_head);
  end

  // Fetching is held off for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= disable_signal;
    end else begin
      running <= enable_signal;
    end
  end

  // PC register: a redirect reloads it even before running, otherwise it steps on fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_flag_i) begin
      pc <= word_align(branch_target_i);
    end else if (fetch) begin
      pc <= pc + PC_STEP;
    end else begin
      pc <= pc;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (branch_flag_i),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Output drive; the FIFO already presents a zero head when empty.
  always_comb begin
    rom_ce_o   = ce;
    rom_addr_o = pc;
    id_valid_o = ~fifo_empty;
    if (fifo_empty) begin
      id_inst_o = zero_word;
      id_pc_o   = zero_word;
    end else begin
      id_inst_o = head_entry.inst;
      id_pc_o   = head_entry.pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random traffic
// compared against a queue-based reference model; a second instance checks PC wrap.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFF8;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] ROM_KEY    = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch;
  logic [31:0] target;
  logic        id_valid;
  logic        ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  logic        rst_b;
  logic        rom_ce_b;
  logic [31:0] rom_addr_b;
  logic [31:0] rom_inst_b;
  logic        branch_b;
  logic [31:0] target_b;
  logic        id_valid_b;
  logic        ready_b;
  logic [31:0] id_inst_b;
  logic [31:0] id_pc_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] mq [$];
  logic [31:0] m_pc;
  bit          m_run;

  assign rom_inst   = rom_addr ^ ROM_KEY;
  assign rom_inst_b = rom_addr_b ^ ROM_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC_A), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .rom_inst_i      (rom_inst),
    .branch_flag_i   (branch),
    .branch_target_i (target),
    .id_valid_o      (id_valid),
    .id_ready_i      (ready),
    .id_inst_o       (id_inst),
    .id_pc_o         (id_pc)
  );

  inst_fetch_unit #(.RESET_PC(RESET_PC_B), .BUF_DEPTH(DEPTH)) dut_b (
    .clk             (clk),
    .rst             (rst_b),
    .rom_ce_o        (rom_ce_b),
    .rom_addr_o      (rom_addr_b),
    .rom_inst_i      (rom_inst_b),
    .branch_flag_i   (branch_b),
    .branch_target_i (target_b),
    .id_valid_o      (id_valid_b),
    .id_ready_i      (ready_b),
    .id_inst_o       (id_inst_b),
    .id_pc_o         (id_pc_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cycle(input logic br, input logic [31:0] tgt, input logic rdy);
    logic [63:0] hd;
    bit          exp_ce;
    bit          do_fetch;
    bit          do_pop;
    branch = br;
    target = tgt;
    ready  = rdy;
    @(negedge clk);
    exp_ce = m_run && (mq.size() < DEPTH);
    hd     = (mq.size() != 0) ? mq[0] : 64'h0;
    check("rom_ce",   {63'h0, rom_ce},   {63'h0, exp_ce});
    check("rom_addr", {32'h0, rom_addr}, {32'h0, m_pc});
    check("id_valid", {63'h0, id_valid}, {63'h0, (mq.size() != 0)});
    check("id_pc",    {32'h0, id_pc},    {32'h0, hd[63:32]});
    check("id_inst",  {32'h0, id_inst},  {32'h0, hd[31:0]});
    do_fetch = exp_ce && !br;
    do_pop   = (mq.size() != 0) && rdy;
    if (br) begin
      mq.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_fetch) begin
        mq.push_back({m_pc, m_pc ^ ROM_KEY});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must respond at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    m_pc  = RESET_PC_A;
    m_run = 1'b0;
    check("rst_ce",    {63'h0, rom_ce},   64'h0);
    check("rst_addr",  {32'h0, rom_addr}, {32'h0, RESET_PC_A});
    check("rst_valid", {63'h0, id_valid}, 64'h0);
    check("rst_pc",    {32'h0, id_pc},    64'h0);
    check("rst_inst",  {32'h0, id_inst},  64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] b_exp [4];
    logic        r_br;
    logic [31:0] r_tgt;
    logic        r_rdy;

    rst      = 1'b0;
    rst_b    = 1'b0;
    branch   = 1'b0;
    target   = 32'h0;
    ready    = 1'b0;
    branch_b = 1'b0;
    target_b = 32'h0;
    ready_b  = 1'b1;
    #1 rst_b = 1'b1;

    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1);

    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0103, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

    cycle(1'b1, 32'h0000_0200, 1'b1);
    cycle(1'b1, 32'h0000_0300, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      r_br  = ($urandom_range(0, 9) == 0);
      r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'h0000_000F))
                                          : $urandom();
      r_rdy = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(r_br, r_tgt, r_rdy);
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
    do_reset();
    cycle(1'b1, 32'h0000_0042, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    b_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("wrap_ce0",   {63'h0, rom_ce_b},   64'h0);
        check("wrap_addr0", {32'h0, rom_addr_b}, {32'h0, RESET_PC_B});
      end else if (k <= 4) begin
        check("wrap_ce",   {63'h0, rom_ce_b},   64'h1);
        check("wrap_addr", {32'h0, rom_addr_b}, {32'h0, b_exp[k-1]});
      end
      if (k >= 2) begin
        check("wrap_valid", {63'h0, id_valid_b}, 64'h1);
        check("wrap_pc",    {32'h0, id_pc_b},    {32'h0, b_exp[k-2]});
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
